// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Widths default to the data-memory word and address widths.
package dmem_arb_pkg;

    localparam int DMEM_DW = 32;
    localparam int DMEM_AW = 8;

    localparam int STARVE_DEF = 4;
    localparam int STARVE_CW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PU   = 2'd1,
        HOST = 2'd2,
        LOCK = 2'd3
    } state_t;

    localparam logic TAG_PU   = 1'b0;
    localparam logic TAG_HOST = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// PU, host and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arb_if #(
    parameter int DW = dmem_arb_pkg::DMEM_DW,
    parameter int AW = dmem_arb_pkg::DMEM_AW
);
    logic          pu_req;
    logic          pu_we;
    logic [AW-1:0] pu_addr;
    logic [DW-1:0] pu_wd;
    logic          pu_stall;
    logic          pu_rvalid;
    logic [DW-1:0] pu_rd;

    logic          h_req;
    logic          h_we;
    logic          h_lock;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] h_rd;

    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd;

    modport slave (
        input  pu_req, pu_we, pu_addr, pu_wd,
        input  h_req, h_we, h_lock, h_addr, h_wd,
        input  m_rd,
        output pu_stall, pu_rvalid, pu_rd,
        output h_gnt, h_rvalid, h_rd,
        output m_we, m_addr, m_wd
    );

    modport master (
        output pu_req, pu_we, pu_addr, pu_wd,
        output h_req, h_we, h_lock, h_addr, h_wd,
        output m_rd,
        input  pu_stall, pu_rvalid, pu_rd,
        input  h_gnt, h_rvalid, h_rd,
        input  m_we, m_addr, m_wd
    );
endinterface

// File: rtl/dmem_arb_rdret.sv
// Read-return steering: remembers which requester issued the read and routes m_rd back.
// Latency: rvalid/rd one cycle after the granted read; reset drops a pending return.
// Backpressure: none, every granted read returns unconditionally.
module dmem_arb_rdret
    import dmem_arb_pkg::*;
#(
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_go,
    input  logic          rd_tag,
    input  logic [DW-1:0] m_rd,
    output logic          pu_rvalid,
    output logic [DW-1:0] pu_rd,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rd
);
    logic          pend_q;
    logic          tag_q;
    logic [DW-1:0] pu_rd_q;
    logic [DW-1:0] h_rd_q;

    // Gating with rst drops a return that was in flight when reset arrived.
    assign pu_rvalid = rst & pend_q & (tag_q == TAG_PU);
    assign h_rvalid  = rst & pend_q & (tag_q == TAG_HOST);
    assign pu_rd     = pu_rvalid ? m_rd : pu_rd_q;
    assign h_rd      = h_rvalid  ? m_rd : h_rd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q  <= 1'b0;
            tag_q   <= TAG_PU;
            pu_rd_q <= '0;
            h_rd_q  <= '0;
        end else begin
            pend_q  <= rd_go;
            if (rd_go) begin
                tag_q <= rd_tag;
            end
            pu_rd_q <= pu_rd;
            h_rd_q  <= h_rd;
        end
    end
endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter (PU / host) for the single-port data memory; optional DMEM_ARB_RR_EN.
// Latency: grant and memory drive same cycle, read data one cycle later.
// Backpressure: losing PU sees pu_stall; host holds h_req until h_gnt.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int DW     = DMEM_DW,
    parameter int AW     = DMEM_AW,
    parameter int STARVE = STARVE_DEF
) (
    input logic       clk,
    input logic       rst,
    dmem_arb_if.slave bus
);
    localparam logic [STARVE_CW-1:0] STARVE_MAX = STARVE_CW'(STARVE);

    state_t               st_q, st_d;
    logic [STARVE_CW-1:0] starve_q, starve_d;
    logic                 pu_win, h_win;
    logic                 lock_hold, h_starved;
    logic                 rd_go, rd_tag;

`ifdef DMEM_ARB_RR_EN
    logic last_host_q;
`endif

    always_comb begin
        pu_win    = 1'b0;
        h_win     = 1'b0;
        lock_hold = (st_q == LOCK) && bus.h_req && bus.h_lock;
        h_starved = bus.h_req && (starve_q == STARVE_MAX);
        // Nobody is granted while reset is asserted.
        if (rst) begin
            if (lock_hold || h_starved) begin
                h_win = 1'b1;
`ifdef DMEM_ARB_RR_EN
            end else if (bus.pu_req && bus.h_req) begin
                h_win  = ~last_host_q;
                pu_win = last_host_q;
`endif
            end else if (bus.pu_req) begin
                pu_win = 1'b1;
            end else if (bus.h_req) begin
                h_win = 1'b1;
            end
        end

        st_d = IDLE;
        if (pu_win) begin
            st_d = PU;
        end else if (h_win) begin
            st_d = bus.h_lock ? LOCK : HOST;
        end

        starve_d = starve_q;
        if (!bus.h_req || h_win) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        bus.m_we   = 1'b0;
        bus.m_addr = '0;
        bus.m_wd   = '0;
        if (pu_win) begin
            bus.m_we   = bus.pu_we;
            bus.m_addr = bus.pu_addr;
            bus.m_wd   = bus.pu_wd;
        end else if (h_win) begin
            bus.m_we   = bus.h_we;
            bus.m_addr = bus.h_addr;
            bus.m_wd   = bus.h_wd;
        end

        bus.pu_stall = bus.pu_req & ~pu_win;
        bus.h_gnt    = bus.h_req & h_win;
        rd_go        = (pu_win & ~bus.pu_we) | (h_win & ~bus.h_we);
        rd_tag       = h_win ? TAG_HOST : TAG_PU;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= IDLE;
            starve_q <= '0;
        end else begin
            st_q     <= st_d;
            starve_q <= starve_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset value lets the PU win the first contended cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_host_q <= 1'b1;
        end else if (h_win) begin
            last_host_q <= 1'b1;
        end else if (pu_win) begin
            last_host_q <= 1'b0;
        end
    end
`endif

    dmem_arb_rdret #(.DW(DW)) u_rdret (
        .clk       (clk),
        .rst       (rst),
        .rd_go     (rd_go),
        .rd_tag    (rd_tag),
        .m_rd      (bus.m_rd),
        .pu_rvalid (bus.pu_rvalid),
        .pu_rd     (bus.pu_rd),
        .h_rvalid  (bus.h_rvalid),
        .h_rd      (bus.h_rd)
    );
endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a registered-read memory model behind the arbiter.
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] mem [0:255];

    dmem_arb_if #(.DW(32), .AW(8)) bus ();

    dmem_arb #(.DW(32), .AW(8), .STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.m_we) mem[bus.m_addr] <= bus.m_wd;
        bus.m_rd <= mem[bus.m_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pset(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        bus.pu_req  = req;
        bus.pu_we   = we;
        bus.pu_addr = addr;
        bus.pu_wd   = wd;
    endtask

    task automatic hset(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [31:0] wd);
        bus.h_req  = req;
        bus.h_we   = we;
        bus.h_lock = lock;
        bus.h_addr = addr;
        bus.h_wd   = wd;
    endtask

    initial begin
        logic exp_h, prev_h, prev_pu;
        logic [7:0] pre_addr [5];
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        pre_addr = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8};

        // Reset held for two edges with the PU requesting.
        rst = 1'b0;
        pset(1, 0, 8'd0, 32'h0);
        hset(0, 0, 0, 8'd0, 32'h0);
        @(negedge clk); #4;
        chk("rst_stall", 32'(bus.pu_stall), 32'd1);
        chk("rst_mwe", 32'(bus.m_we), 32'd0);
        chk("rst_maddr", 32'(bus.m_addr), 32'd0);
        chk("rst_hgnt", 32'(bus.h_gnt), 32'd0);
        chk("rst_purv", 32'(bus.pu_rvalid), 32'd0);
        chk("rst_hrv", 32'(bus.h_rvalid), 32'd0);
        chk("rst_purd", bus.pu_rd, 32'h0);
        chk("rst_hrd", bus.h_rd, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pset(0, 0, 8'd0, 32'h0);
        #4;
        chk("rel_state", 32'(dut.st_q), 32'(IDLE));
        chk("rel_stall", 32'(bus.pu_stall), 32'd0);

        // Host write then read of address 5.
        @(negedge clk);
        hset(1, 1, 0, 8'd5, 32'hA5A5);
        #4;
        chk("hw_gnt", 32'(bus.h_gnt), 32'd1);
        chk("hw_mwe", 32'(bus.m_we), 32'd1);
        chk("hw_maddr", 32'(bus.m_addr), 32'd5);
        chk("hw_mwd", bus.m_wd, 32'hA5A5);
        @(negedge clk);
        hset(1, 0, 0, 8'd5, 32'h0);
        #4;
        chk("hr_gnt", 32'(bus.h_gnt), 32'd1);
        chk("hr_mwe", 32'(bus.m_we), 32'd0);
        chk("hr_rv_early", 32'(bus.h_rvalid), 32'd0);
        @(negedge clk);
        hset(0, 0, 0, 8'd0, 32'h0);
        #4;
        chk("hr_rv", 32'(bus.h_rvalid), 32'd1);
        chk("hr_rd", bus.h_rd, 32'hA5A5);
        chk("hr_purv", 32'(bus.pu_rvalid), 32'd0);

        // Preload through the host port.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hset(1, 1, 0, pre_addr[i], 32'hD000 + 32'(pre_addr[i]));
            #4;
            chk("pre_gnt", 32'(bus.h_gnt), 32'd1);
        end
        @(negedge clk);
        hset(0, 0, 0, 8'd0, 32'h0);

        // Alternating reads: PU addr 7, then host addr 8.
        @(negedge clk);
        pset(1, 0, 8'd7, 32'h0);
        #4;
        chk("alt_pu_stall", 32'(bus.pu_stall), 32'd0);
        chk("alt_pu_maddr", 32'(bus.m_addr), 32'd7);
        @(negedge clk);
        pset(0, 0, 8'd0, 32'h0);
        hset(1, 0, 0, 8'd8, 32'h0);
        #4;
        chk("alt_h_gnt", 32'(bus.h_gnt), 32'd1);
        chk("alt_purv", 32'(bus.pu_rvalid), 32'd1);
        chk("alt_purd", bus.pu_rd, 32'hD007);
        chk("alt_hrv0", 32'(bus.h_rvalid), 32'd0);
        chk("alt_hrd_hold", bus.h_rd, 32'hA5A5);
        @(negedge clk);
        hset(0, 0, 0, 8'd0, 32'h0);
        #4;
        chk("alt_hrv", 32'(bus.h_rvalid), 32'd1);
        chk("alt_hrd", bus.h_rd, 32'hD008);
        chk("alt_purv0", 32'(bus.pu_rvalid), 32'd0);
        chk("alt_purd_hold", bus.pu_rd, 32'hD007);

        // Continuous contention for ten cycles.
        prev_h  = 1'b0;
        prev_pu = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            pset(1, 0, 8'd7, 32'h0);
            hset(1, 0, 0, 8'd8, 32'h0);
`ifdef DMEM_ARB_RR_EN
            exp_h = (i % 2 == 0);
`else
            exp_h = (i % 5 == 0);
`endif
            #4;
            chk("con_hgnt", 32'(bus.h_gnt), 32'(exp_h));
            chk("con_stall", 32'(bus.pu_stall), 32'(exp_h));
            chk("con_purv", 32'(bus.pu_rvalid), 32'(prev_pu));
            chk("con_hrv", 32'(bus.h_rvalid), 32'(prev_h));
            if (prev_pu) chk("con_purd", bus.pu_rd, 32'hD007);
            if (prev_h) chk("con_hrd", bus.h_rd, 32'hD008);
            prev_h  = exp_h;
            prev_pu = ~exp_h;
        end

        // Locked host burst; the PU write request during it must not reach memory.
        @(negedge clk);
        pset(0, 0, 8'd0, 32'h0);
        hset(1, 0, 1, 8'd2, 32'h0);
        #4;
        chk("lk_entry_gnt", 32'(bus.h_gnt), 32'd1);
        chk("lk_entry_hrd", bus.h_rd, 32'hD008);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pset(1, 1, 8'd7, 32'hBAD);
            hset(1, 0, 1, 8'(k), 32'h0);
            #4;
            chk("lk_gnt", 32'(bus.h_gnt), 32'd1);
            chk("lk_stall", 32'(bus.pu_stall), 32'd1);
            chk("lk_mwe", 32'(bus.m_we), 32'd0);
            chk("lk_maddr", 32'(bus.m_addr), 32'(k));
            chk("lk_hrv", 32'(bus.h_rvalid), 32'd1);
            chk("lk_hrd", bus.h_rd, (k == 0) ? 32'hD002 : 32'hD000 + 32'(k - 1));
        end
        @(negedge clk);
        pset(1, 0, 8'd7, 32'h0);
        hset(1, 0, 0, 8'd3, 32'h0);
        #4;
        chk("lk_exit_stall", 32'(bus.pu_stall), 32'd0);
        chk("lk_exit_hgnt", 32'(bus.h_gnt), 32'd0);
        chk("lk_exit_maddr", 32'(bus.m_addr), 32'd7);
        chk("lk_exit_hrd", bus.h_rd, 32'hD002);
        @(negedge clk);
        pset(0, 0, 8'd0, 32'h0);
        hset(0, 0, 0, 8'd0, 32'h0);
        #4;
        chk("lk_after_purv", 32'(bus.pu_rvalid), 32'd1);
        chk("lk_after_purd", bus.pu_rd, 32'hD007);
        chk("lk_after_hrv", 32'(bus.h_rvalid), 32'd0);

        // PU write then read of the same address.
        @(negedge clk);
        pset(1, 1, 8'd9, 32'hDEAD);
        #4;
        chk("pw_mwe", 32'(bus.m_we), 32'd1);
        chk("pw_maddr", 32'(bus.m_addr), 32'd9);
        chk("pw_mwd", bus.m_wd, 32'hDEAD);
        @(negedge clk);
        pset(1, 0, 8'd9, 32'h0);
        #4;
        chk("pr_mwe", 32'(bus.m_we), 32'd0);
        chk("pr_purv0", 32'(bus.pu_rvalid), 32'd0);
        @(negedge clk);
        pset(0, 0, 8'd0, 32'h0);
        #4;
        chk("pr_purv", 32'(bus.pu_rvalid), 32'd1);
        chk("pr_purd", bus.pu_rd, 32'hDEAD);

        // Reset arriving while a PU read is in flight.
        @(negedge clk);
        pset(1, 0, 8'd8, 32'h0);
        #4;
        chk("mr_stall", 32'(bus.pu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pset(0, 0, 8'd0, 32'h0);
        #4;
        chk("mr_purv", 32'(bus.pu_rvalid), 32'd0);
        @(negedge clk);
        #4;
        chk("mr_purv2", 32'(bus.pu_rvalid), 32'd0);
        chk("mr_purd", bus.pu_rd, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #4;
        chk("mr_rel_purv", 32'(bus.pu_rvalid), 32'd0);
        chk("mr_rel_state", 32'(dut.st_q), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Two-requester arbiter for the single-port data memory.
- Shares the memory between the PU load/store path (requester 0) and a host/loader port (requester 1). The host port preloads data and reads back results while the PU runs.
- Emits a stall to the PU whenever its access is not granted.
- Sits between the decoder/ALU address path and the data memory; 1-cycle registered read latency.

Parameters:
- DW, 32, data word width (bits).
- AW, 8, word address width (bits).
- STARVE, 4, consecutive cycles the host may be denied before forced grant; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- pu_req  in  1  PU access request, single-cycle-qualified.
- pu_we  in  1  PU write enable (1=write, 0=read).
- pu_addr  in  AW  PU word address.
- pu_wd  in  DW  PU write data.
- pu_stall  out  1  PU request present but not granted this cycle.
- pu_rvalid  out  1  PU read data valid.
- pu_rd  out  DW  PU read data.
- h_req  in  1  host request; held until granted.
- h_we  in  1  host write enable.
- h_lock  in  1  host keeps grant across back-to-back requests (burst).
- h_addr  in  AW  host word address.
- h_wd  in  DW  host write data.
- h_gnt  out  1  host request accepted this cycle.
- h_rvalid  out  1  host read data valid.
- h_rd  out  DW  host read data.
- m_we  out  1  memory write strobe.
- m_addr  out  AW  memory address.
- m_wd  out  DW  memory write data.
- m_rd  in  DW  memory read data, valid 1 cycle after read address.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, starve count=0, pu_rvalid=h_rvalid=0, m_we=0, m_addr=0, m_wd=0, h_gnt=0, pu_rd=h_rd=0. pu_stall is combinational and equals pu_req during reset.
- Arbitration is combinational per cycle. Winner drives m_addr/m_we/m_wd the same cycle; non-winner sees m_we=0.
- States:
  - IDLE: no owner.
  - PU: PU owned last cycle.
  - HOST: host owned last cycle.
  - LOCK: host holds burst ownership.
- Priority rule, non-LOCK states: PU wins if pu_req, except host wins when h_req and starve count==STARVE.
- LOCK: host wins while h_req&h_lock. PU stalls, regardless of starvation.
  - Exit LOCK when h_lock==0 or h_req==0, evaluated in the same cycle; that cycle falls back to normal priority.
- Transitions:
  - any state -> PU when PU wins.
  - -> HOST when host wins with h_lock=0.
  - -> LOCK when host wins with h_lock=1.
  - -> IDLE when neither requests.
- Starve counter:
  - Increments each cycle h_req is asserted and host loses; saturates at STARVE.
  - Clears on host grant or when h_req==0.
- pu_stall = pu_req & ~(PU wins).
- h_gnt = h_req & (host wins); host may change request the cycle after h_gnt.
- Reads:
  - Winner's read registers a tag (0/1).
  - Next cycle: that requester's rvalid=1 and its rd=m_rd; the other rd holds its previous value.
  - Writes produce no rvalid.
- Back-to-back reads from alternating requesters are pipelined; one grant per cycle, full throughput.
- Same-address write by host and read by PU in the same cycle is impossible (one grant). Write-then-read next cycle returns new data; this is a memory property, verified end to end.
- Reset mid-read: pending rvalid is dropped.

Optional Feature:
- DMEM_ARB_RR_EN:
  - Defined: non-LOCK priority becomes round-robin. The requester not granted most recently wins on contention; starvation counter still present but unreachable beyond 1.
  - Undefined: PU priority with STARVE forcing, as above.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum (IDLE, PU, HOST, LOCK).
  - requester tag constants TAG_PU=0, TAG_HOST=1.
  - default widths tied to existing data-memory width macros.
- One natural sub-module: dmem_arb_rdret, the read-return tag register and rvalid/rd steering. The arbiter FSM and starve counter stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with pu_req=1 -> all rvalid=0, m_we=0, h_gnt=0, pu_stall=1; release -> state IDLE.
- Host write then read, PU idle: h_req,h_we=1,addr=5,wd=0xA5A5 -> h_gnt, m_we=1. Then read addr 5 -> h_rvalid next cycle with h_rd=0xA5A5.
- Contention, STARVE=4: pu_req and h_req continuously.
  - Default build: host granted on 5th cycle only, then PU again; pu_stall=1 exactly that cycle.
  - With DMEM_ARB_RR_EN: grants alternate every cycle.
- Host burst: h_lock=1, 3 back-to-back reads addr 0,1,2 while pu_req=1 -> pu_stall=1 for 3 cycles, h_rvalid on cycles 2-4 with correct data. h_lock=0 -> PU granted the next cycle.
- Alternating reads PU addr 7 / host addr 8 -> each rvalid asserted only on owner's port, 1-cycle latency, other port's rd unchanged.
- Reset mid-read: PU read granted, rst=0 next cycle -> pu_rvalid stays 0.
